// File: rtl/l1_l2_arbiter_pkg.sv
// Shared types for the L1 <-> L2 line arbiter.
package l1_l2_arbiter_pkg;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } arb_owner_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } arb_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    FINISH = 2'd2
  } l1l2_state_t;

endpackage

// File: rtl/l1_l2_arbiter_if.sv
// Cache-line port: request strobes, address and write line from the master,
// returned line and one-cycle completion from the slave.
interface l1_l2_arbiter_if #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [LINE_W-1:0] wdata;
  logic [LINE_W-1:0] rdata;
  logic              resp;

  modport master (output read, write, addr, wdata, input rdata, resp);
  modport slave  (input read, write, addr, wdata, output rdata, resp);
endinterface

// File: rtl/l1_l2_arbiter_rr_grant2.sv
// Two-way grant selection between icache and dcache, with the last-grant flop.
module rr_grant2
  import l1_l2_arbiter_pkg::*;
#(
  parameter int unsigned RR_ENABLE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_i,
  input  logic       req_d,
  input  logic       grant,
  output arb_owner_t winner
);

  arb_owner_t last_grant;

  // Winner: lone requester, else round-robin or fixed dcache priority.
  always_comb begin
    winner = DCACHE;
    if (req_i && !req_d)
      winner = ICACHE;
    else if (req_i && req_d && (RR_ENABLE != 0) && (last_grant == DCACHE))
      winner = ICACHE;
  end

  // Remember who was granted last so ties alternate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_grant <= DCACHE;
    else if (grant)
      last_grant <= winner;
  end

endmodule

// File: rtl/l1_l2_arbiter.sv
// Shares the single L2 line port between the L1 icache and dcache, one
// transaction at a time, with registered L2 drive and a one-cycle response.
module l1_l2_arbiter
  import l1_l2_arbiter_pkg::*;
#(
  parameter int unsigned LINE_W    = 256,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned RR_ENABLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  l1_l2_arbiter_if.slave   icache,
  l1_l2_arbiter_if.slave   dcache,
  l1_l2_arbiter_if.master  l2
);

  l1l2_state_t       state;
  logic [ADDR_W-1:0] addr_reg;
  logic [LINE_W-1:0] wdata_reg;
  logic [LINE_W-1:0] rdata_reg;
  arb_owner_t        owner_reg;
  arb_op_t           op_reg;

  logic              any_req;
  logic              grant;
  arb_owner_t        winner;
  arb_op_t           win_op;

  assign any_req = icache.read || dcache.read || dcache.write;
  assign grant   = (state == IDLE) && any_req;

  rr_grant2 #(
    .RR_ENABLE (RR_ENABLE)
  ) u_grant (
    .clk    (clk),
    .reset  (reset),
    .req_i  (icache.read),
    .req_d  (dcache.read || dcache.write),
    .grant  (grant),
    .winner (winner)
  );

  // A dcache write takes precedence over a simultaneous dcache read.
  always_comb begin
    win_op = OP_READ;
    if (winner == DCACHE && dcache.write)
      win_op = OP_WRITE;
  end

  // Transaction sequencing plus grant-time capture of addr/wdata/op/owner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      owner_reg <= DCACHE;
      op_reg    <= OP_READ;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner_reg <= winner;
            op_reg    <= win_op;
            addr_reg  <= (winner == DCACHE) ? dcache.addr : icache.addr;
            if (win_op == OP_WRITE)
              wdata_reg <= dcache.wdata;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (l2.resp) begin
            if (op_reg == OP_READ)
              rdata_reg <= l2.rdata;
            state <= FINISH;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are pure decodes of registered state, so reset drops them at once.
  always_comb begin
    l2.read      = (state == BUSY) && (op_reg == OP_READ);
    l2.write     = (state == BUSY) && (op_reg == OP_WRITE);
    l2.addr      = addr_reg;
    l2.wdata     = wdata_reg;
    icache.resp  = (state == FINISH) && (owner_reg == ICACHE);
    dcache.resp  = (state == FINISH) && (owner_reg == DCACHE);
    icache.rdata = rdata_reg;
    dcache.rdata = rdata_reg;
  end

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Directed bench for l1_l2_arbiter: latency, write path, arbitration order for
// both arbitration modes, async reset mid-transaction, spurious L2 responses.
module tb_l1_l2_arbiter;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  l1_l2_arbiter_if #(.LINE_W(256), .ADDR_W(32)) ic0 ();
  l1_l2_arbiter_if #(.LINE_W(256), .ADDR_W(32)) dc0 ();
  l1_l2_arbiter_if #(.LINE_W(256), .ADDR_W(32)) l2_0 ();
  l1_l2_arbiter_if #(.LINE_W(256), .ADDR_W(32)) ic1 ();
  l1_l2_arbiter_if #(.LINE_W(256), .ADDR_W(32)) dc1 ();
  l1_l2_arbiter_if #(.LINE_W(256), .ADDR_W(32)) l2_1 ();

  l1_l2_arbiter #(.LINE_W(256), .ADDR_W(32), .RR_ENABLE(1)) dut_rr (
    .clk    (clk),
    .reset  (reset),
    .icache (ic0),
    .dcache (dc0),
    .l2     (l2_0)
  );

  l1_l2_arbiter #(.LINE_W(256), .ADDR_W(32), .RR_ENABLE(0)) dut_fx (
    .clk    (clk),
    .reset  (reset),
    .icache (ic1),
    .dcache (dc1),
    .l2     (l2_1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // dcache must never raise read and write together.
  always @(negedge clk) begin
    if (!reset) begin
      assert (!(dc0.read && dc0.write) && !(dc1.read && dc1.write))
      else begin
        errors++;
        $error("FAIL d_read_write_both observed=1 expected=0");
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic l2_busy(input int sel);
    if (sel == 0) return l2_0.read | l2_0.write;
    return l2_1.read | l2_1.write;
  endfunction

  // Wait (bounded) for the L2 strobe, answer it, then report which L1 got resp.
  task automatic serve(input int sel, input logic [255:0] line,
                       output int who, output logic [255:0] got);
    int n;
    n   = 0;
    who = -1;
    got = '0;
    while (!l2_busy(sel) && n < 20) begin
      tick();
      n++;
    end
    chk("serve_strobe", l2_busy(sel), 1'b1);
    if (sel == 0) begin l2_0.rdata = line; l2_0.resp = 1'b1; end
    else          begin l2_1.rdata = line; l2_1.resp = 1'b1; end
    tick();
    if (sel == 0) begin
      l2_0.resp = 1'b0;
      if (ic0.resp)      begin who = 0; got = ic0.rdata; ic0.read = 1'b0; end
      else if (dc0.resp) begin who = 1; got = dc0.rdata; dc0.read = 1'b0; end
    end else begin
      l2_1.resp = 1'b0;
      if (ic1.resp)      begin who = 0; got = ic1.rdata; ic1.read = 1'b0; end
      else if (dc1.resp) begin who = 1; got = dc1.rdata; dc1.read = 1'b0; end
    end
    tick();
  endtask

  // Four back-to-back simultaneous read pairs; first/second are expected owners.
  task automatic pairs(input int sel, input int first, input int second);
    int w1, w2;
    logic [255:0] g1, g2, ln;
    for (int p = 0; p < 4; p++) begin
      if (sel == 0) begin
        ic0.read = 1'b1; ic0.addr = 32'h0000_8000 + 32'(p * 64);
        dc0.read = 1'b1; dc0.addr = 32'h0000_9000 + 32'(p * 64);
      end else begin
        ic1.read = 1'b1; ic1.addr = 32'h0000_8000 + 32'(p * 64);
        dc1.read = 1'b1; dc1.addr = 32'h0000_9000 + 32'(p * 64);
      end
      ln = {8{32'hC0DE_0000 + 32'(p)}};
      serve(sel, ln, w1, g1);
      serve(sel, ~ln, w2, g2);
      chk(sel == 0 ? "rr_first" : "fx_first", 256'(w1), 256'(first));
      chk(sel == 0 ? "rr_second" : "fx_second", 256'(w2), 256'(second));
      chk("pair_rdata1", g1, ln);
      chk("pair_rdata2", g2, ~ln);
    end
  endtask

  int           who;
  logic [255:0] got;

  initial begin
    {ic0.read, ic0.write, ic0.addr, ic0.wdata} = '0;
    {dc0.read, dc0.write, dc0.addr, dc0.wdata} = '0;
    {l2_0.rdata, l2_0.resp} = '0;
    {ic1.read, ic1.write, ic1.addr, ic1.wdata} = '0;
    {dc1.read, dc1.write, dc1.addr, dc1.wdata} = '0;
    {l2_1.rdata, l2_1.resp} = '0;
    reset = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_l2_read", l2_0.read, 1'b0);
    chk("rst_l2_write", l2_0.write, 1'b0);
    chk("rst_l2_addr", l2_0.addr, 32'h0);
    chk("rst_i_resp", ic0.resp, 1'b0);
    chk("rst_d_resp", dc0.resp, 1'b0);
    reset = 1'b0;
    tick();

    // 1: icache read, L2 answers in cycle 4, i_resp in cycle 5
    ic0.read = 1'b1;
    ic0.addr = 32'h0000_1000;
    chk("s1_c0_l2_read", l2_0.read, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("s1_l2_read", l2_0.read, 1'b1);
      chk("s1_i_resp_early", ic0.resp, 1'b0);
      if (c == 4) begin
        l2_0.rdata = {32{8'hA5}};
        l2_0.resp  = 1'b1;
      end
    end
    chk("s1_l2_addr", l2_0.addr, 32'h0000_1000);
    tick();
    l2_0.resp = 1'b0;
    chk("s1_i_resp", ic0.resp, 1'b1);
    chk("s1_i_rdata", ic0.rdata, {32{8'hA5}});
    chk("s1_d_resp", dc0.resp, 1'b0);
    chk("s1_l2_read_off", l2_0.read, 1'b0);
    ic0.read = 1'b0;
    tick();
    chk("s1_i_resp_once", ic0.resp, 1'b0);

    // 2: dcache writeback, L2 answers in cycle 1, d_resp in cycle 2
    dc0.write = 1'b1;
    dc0.addr  = 32'h0000_2040;
    dc0.wdata = {8{32'h1234_5678}};
    tick();
    chk("s2_l2_write", l2_0.write, 1'b1);
    chk("s2_l2_read", l2_0.read, 1'b0);
    chk("s2_l2_addr", l2_0.addr, 32'h0000_2040);
    chk("s2_l2_wdata", l2_0.wdata, {8{32'h1234_5678}});
    l2_0.resp = 1'b1;
    tick();
    l2_0.resp = 1'b0;
    chk("s2_d_resp", dc0.resp, 1'b1);
    chk("s2_i_resp", ic0.resp, 1'b0);
    dc0.write = 1'b0;
    tick();
    chk("s2_d_resp_once", dc0.resp, 1'b0);

    // 3/4: simultaneous reads from reset; RR alternates, fixed favours dcache
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    pairs(0, 0, 1);
    pairs(1, 1, 0);

    // 5: async reset during BUSY drops the strobe immediately, no resp follows
    ic0.read = 1'b1;
    ic0.addr = 32'h0000_3000;
    tick();
    chk("s5_busy", l2_0.read, 1'b1);
    reset = 1'b1;
    #1;
    chk("s5_l2_read_drop", l2_0.read, 1'b0);
    chk("s5_addr_clr", l2_0.addr, 32'h0);
    ic0.read = 1'b0;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("s5_no_i_resp", ic0.resp, 1'b0);
      chk("s5_no_d_resp", dc0.resp, 1'b0);
    end
    dc0.read = 1'b1;
    dc0.addr = 32'h0000_4000;
    tick();
    chk("s5_next_addr", l2_0.addr, 32'h0000_4000);
    dc0.read = 1'b1;
    serve(0, {4{64'hDEAD_BEEF_0BAD_F00D}}, who, got);
    chk("s5_next_who", 256'(who), 256'(1));
    chk("s5_next_rdata", got, {4{64'hDEAD_BEEF_0BAD_F00D}});

    // 6: spurious l2_resp in IDLE; address change during BUSY ignored
    l2_0.resp = 1'b1;
    tick();
    l2_0.resp = 1'b0;
    chk("s6_spur_i_resp", ic0.resp, 1'b0);
    chk("s6_spur_d_resp", dc0.resp, 1'b0);
    chk("s6_spur_l2_read", l2_0.read, 1'b0);
    tick();
    chk("s6_spur_i_resp2", ic0.resp, 1'b0);
    chk("s6_spur_d_resp2", dc0.resp, 1'b0);
    ic0.read = 1'b1;
    ic0.addr = 32'h0000_5000;
    tick();
    ic0.addr = 32'h0000_6000;
    tick();
    chk("s6_addr_hold", l2_0.addr, 32'h0000_5000);
    chk("s6_still_busy", l2_0.read, 1'b1);
    serve(0, {16{16'h5A5A}}, who, got);
    chk("s6_who", 256'(who), 256'(0));
    chk("s6_rdata", got, {16{16'h5A5A}});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
